instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, opcode classes, jump conditions.
package cpu_pkg;

  // Fetch/decode FSM states.
  typedef enum logic [2:0] {
    StFetch1,
    StFetch2,
    StDecode,
    StIssue,
    StHalt
  } fetch_state_e;

  // Opcode class lives in opcode1[7:6]. ALU is any 1x pattern.
  localparam logic [1:0] OpClassMem    = 2'b00;
  localparam logic [1:0] OpClassJump   = 2'b01;
  localparam logic       OpClassAluBit = 1'b1;

  // Jump condition field, opcode1[5:4].
  typedef enum logic [1:0] {
    JmpAlways  = 2'b00,
    JmpZero    = 2'b01,
    JmpCarry   = 2'b10,
    JmpNotZero = 2'b11
  } jump_cond_e;

  // Default opcode1 value that stops fetching.
  localparam logic [7:0] HaltOpDefault = 8'h00;

  // True when the jump condition holds for the current ALU flags.
  function automatic logic jump_cond_met(jump_cond_e cond, logic zero_f, logic carry_f);
    logic met;
    unique case (cond)
      JmpAlways:  met = 1'b1;
      JmpZero:    met = zero_f;
      JmpCarry:   met = carry_f;
      JmpNotZero: met = ~zero_f;
      default:    met = 1'b0;
    endcase
    return met;
  endfunction

  // True when the opcode belongs to the jump class.
  function automatic logic is_jump_op(logic [7:0] op);
    return op[7:6] == OpClassJump;
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Two-byte instruction fetch unit: fetches opcode1/opcode2 from ROM, resolves
// conditional jumps locally and hands all other instructions to the controller.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter logic [7:0]  HALT_OP = HaltOpDefault
) (
  input  logic              clk,
  input  logic              res,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        opcode1,
  output logic [7:0]        opcode2,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              zero_f,
  input  logic              carry_f,
  output logic [ADDR_W-1:0] pc,
  output logic              jump_taken,
  output logic              halted
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        op1_q, op1_d;
  logic [7:0]        op2_q, op2_d;
  logic              jump_q, jump_d;

  logic dec_halt;
  logic dec_jump;
  logic dec_take;

  // Decode of the held instruction; only acted upon in StDecode.
  always_comb begin
    dec_halt = (op1_q == HALT_OP);
    dec_jump = is_jump_op(op1_q);
    dec_take = jump_cond_met(jump_cond_e'(op1_q[5:4]), zero_f, carry_f);
  end

  // State register.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= StFetch1;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Halt wins over the jump class if HALT_OP encodes a jump.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch1: state_d = StFetch2;
      StFetch2: state_d = StDecode;
      StDecode: begin
        if (dec_halt) begin
          state_d = StHalt;
        end else if (dec_jump) begin
          state_d = StFetch1;
        end else begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (instr_ready) begin
          state_d = StFetch1;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch1;
    endcase
  end

  // Datapath next values: byte capture, pc advance and jump target load.
  always_comb begin
    pc_d   = pc_q;
    op1_d  = op1_q;
    op2_d  = op2_q;
    jump_d = 1'b0;
    unique case (state_q)
      StFetch1: begin
        op1_d = rom_data;
        pc_d  = pc_q + ADDR_W'(1);
      end
      StFetch2: begin
        op2_d = rom_data;
        pc_d  = pc_q + ADDR_W'(1);
      end
      StDecode: begin
        // Not-taken jumps leave pc pointing past the instruction already.
        if (!dec_halt && dec_jump && dec_take) begin
          pc_d   = ADDR_W'(op2_q);
          jump_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      pc_q   <= '0;
      op1_q  <= 8'h00;
      op2_q  <= 8'h00;
      jump_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      op1_q  <= op1_d;
      op2_q  <= op2_d;
      jump_q <= jump_d;
    end
  end

  // Outputs. jump_taken is high during the first fetch cycle at the target.
  always_comb begin
    rom_addr    = pc_q;
    pc          = pc_q;
    opcode1     = op1_q;
    opcode2     = op2_q;
    jump_taken  = jump_q;
    instr_valid = (state_q == StIssue);
    halted      = (state_q == StHalt);
  end

endmodule
